// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the bit-serial adder slice.
//   state_t        : controller state encoding (IDLE / SHIFT / DONE). The
//                    fourth code, 2'd3, is unused and recovers to IDLE.
//   DEFAULT_WIDTH  : default operand / sum width in bits.
//   majority()     : 3-input majority, i.e. the carry function of a full adder.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//
// Launch/collect bundle between a sequencing controller (master) and the
// bit-serial adder (slave).
//   start  master->slave  launch request, sampled by the adder only in IDLE
//   a, b   master->slave  operands, captured on the accepted start edge
//   cin    master->slave  carry-in, captured on the accepted start edge
//   busy   slave->master  high while an add is in flight (SHIFT and DONE)
//   done   slave->master  one-cycle pulse, sum/cout valid from this cycle
//   sum    slave->master  registered result, held until the next result
//   cout   slave->master  registered carry-out, held with sum
//   state  slave->master  current controller state, for observation only
//
// Handshake: the master raises start with a/b/cin valid. The adder accepts
// it on the first rising edge at which it is idle (busy low). It does not
// acknowledge start in any other way: busy rises in the following cycle,
// and start is ignored while busy is high. A start still held high when
// the adder returns to IDLE is accepted at that next edge, which launches
// another add.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
) ();
    import serial_adder_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    state_t           state;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, state
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, state
    );

endinterface : serial_adder_if

// File: rtl/serial_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//
// Purely combinational 1-bit full adder. This is the single arithmetic cell
// that the serial adder reuses on every bit position.
//   x, y  : operand bits
//   ci    : carry in
//   s     : sum bit      = x ^ y ^ ci
//   co    : carry out    = majority(x, y, ci)
// -----------------------------------------------------------------------------
module fa_cell
    import serial_adder_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = majority(x, y, ci);

endmodule : fa_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder. It uses one full-adder cell and one carry
// flip-flop. Operand bits are fed to the cell LSB first, one pair per clock,
// and the sum bits are shifted into a result register from the top. After
// WIDTH shift cycles, the result is copied to the output register and done
// pulses for one cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every register
//   bus    serial_adder_if slave modport (start/a/b/cin in,
//          busy/done/sum/cout/state out)
//
// Timing: when start is accepted at edge E0, done is high during the cycle
// after edge E0+WIDTH, and busy is high for WIDTH+1 cycles. The adder is idle
// again after edge E0+WIDTH+1, so one add completes every WIDTH+2 cycles when
// start is held high.
//
// All outputs come directly from flip-flops. There is no combinational path
// from start, a, b or cin to any output.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    // Counter value on the last shift edge.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_co;

    // The single adder cell always looks at the current LSBs and the stored
    // carry. Its outputs are used only in SHIFT.
    fa_cell u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh    <= bus.a;
                        b_sh    <= bus.b;
                        carry   <= bus.cin;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // The new sum bit enters at the MSB. After WIDTH shifts,
                    // bit 0 of the sum has reached bit 0 of the register.
                    res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // Take the last bit straight from the cell. res_sh
                        // does not hold it until after this edge.
                        sum_q   <= {fa_s, res_sh[WIDTH-1:1]};
                        cout_q  <= fa_co;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    // The unused encoding returns to IDLE. Outputs go quiet
                    // and the last result is kept.
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.state = state_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=3. Expected
// results come from plain integer addition, a + b + cin, which gives the
// (WIDTH+1)-bit value {cout, sum}. The bench checks the hand-written vector
// table, the multi-cycle corner sequences and a random sweep.
// -----------------------------------------------------------------------------
module tb_serial_adder;
    import serial_adder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(3)) bus3 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic st, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
        if (w == 8) begin
            bus8.start = st; bus8.a = a; bus8.b = b; bus8.cin = c;
        end else begin
            bus3.start = st; bus3.a = a[2:0]; bus3.b = b[2:0]; bus3.cin = c;
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? bus8.busy : bus3.busy;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? bus8.done : bus3.done;
    endfunction

    function automatic logic [8:0] get_res(input int w);
        if (w == 8) return {bus8.cout, bus8.sum};
        return {5'b0, bus3.cout, bus3.sum};
    endfunction

    // Reference model: ordinary addition truncated to WIDTH+1 bits.
    function automatic logic [8:0] model(input int w, input logic [7:0] a,
                                         input logic [7:0] b, input logic c);
        if (w == 8) return 9'(a) + 9'(b) + 9'(c);
        return 9'(a[2:0]) + 9'(b[2:0]) + 9'(c);
    endfunction

    // One complete add. Pulse start, scramble the inputs after the accept
    // edge, then follow the operation until busy falls. Latency is counted
    // in edges after the accept edge.
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [8:0] prev,
                          output logic [8:0] res, output int lat,
                          output int busy_n, output int done_n, output int hold_bad);
        res = '0; lat = -1; busy_n = 0; done_n = 0; hold_bad = 0;
        drive(w, 1'b1, a, b, c);
        tick();
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 40; i++) begin
            if (get_busy(w)) busy_n++;
            if (get_done(w)) begin
                done_n++;
                if (lat < 0) begin
                    lat = i;
                    res = get_res(w);
                end
            end else if (lat < 0 && get_res(w) !== prev) begin
                hold_bad++;
            end
            if (!get_busy(w)) break;
            tick();
        end
    endtask

    task automatic wait_idle(input int w, input string name);
        int n;
        n = 0;
        while (get_busy(w) && n < 30) begin
            tick();
            n++;
        end
        check(name, 32'(get_busy(w)), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [8:0] res;
        logic [8:0] prev8;
        logic [8:0] prev3;
        logic [8:0] exp;
        int lat, busy_n, done_n, hold_bad;
        int done_total, hold_total, lat_bad;
        int t_done[$];
        int bad;
        int k;
        logic [7:0] ra, rb;
        logic rc;

        vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[5] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};

        rst_n = 1'b0;
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(3, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_busy8",  32'(bus8.busy), 32'd0);
        check("rst_done8",  32'(bus8.done), 32'd0);
        check("rst_res8",   32'(get_res(8)), 32'd0);
        check("rst_state8", 32'(bus8.state), 32'd0);
        check("rst_busy3",  32'(bus3.busy), 32'd0);
        check("rst_res3",   32'(get_res(3)), 32'd0);
        rst_n = 1'b1;
        tick();
        prev8 = '0;
        prev3 = '0;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            run_op(8, vecs[i].a, vecs[i].b, vecs[i].cin, prev8, res, lat, busy_n, done_n, hold_bad);
            check($sformatf("vec%0d_res", i), 32'(res), 32'({vecs[i].cout, vecs[i].sum}));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_busy", i), 32'(busy_n), 32'd9);
            check($sformatf("vec%0d_done", i), 32'(done_n), 32'd1);
            check($sformatf("vec%0d_hold", i), 32'(hold_bad), 32'd0);
            prev8 = {vecs[i].cout, vecs[i].sum};
            tick();
        end

        // Start held high: back-to-back adds, sum stays put between pulses
        drive(8, 1'b1, 8'h55, 8'hAA, 1'b0);
        bad = 0;
        for (int j = 1; j <= 32; j++) begin
            tick();
            if (bus8.done) begin
                t_done.push_back(j);
                check("held_sum", 32'(get_res(8)), 32'h0FF);
            end
            if (t_done.size() > 0 && get_res(8) !== 9'h0FF) bad++;
        end
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        check("held_pulses", 32'(t_done.size()), 32'd3);
        if (t_done.size() >= 3) begin
            check("held_first", 32'(t_done[0]), 32'd9);
            check("held_gap1", 32'(t_done[1] - t_done[0]), 32'd10);
            check("held_gap2", 32'(t_done[2] - t_done[1]), 32'd10);
        end
        check("held_hold", 32'(bad), 32'd0);
        wait_idle(8, "held_drain");
        prev8 = 9'h0FF;
        tick();

        // Mid-SHIFT disturbance: start and new operands at cycle 3
        drive(8, 1'b1, 8'h12, 8'h34, 1'b0);
        tick();
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        drive(8, 1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        drive(8, 1'b0, 8'hFF, 8'hFF, 1'b1);
        k = 3;
        while (!bus8.done && k < 20) begin
            tick();
            k++;
        end
        check("dist_lat", 32'(k), 32'd8);
        check("dist_res", 32'(get_res(8)), 32'h046);
        wait_idle(8, "dist_idle");
        tick();
        tick();
        check("dist_no_extra", 32'(bus8.busy), 32'd0);
        prev8 = 9'h046;

        // Mid-SHIFT reset: outputs clear without a clock edge
        drive(8, 1'b1, 8'h77, 8'h11, 1'b1);
        tick();
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(bus8.busy), 32'd0);
        check("arst_done",  32'(bus8.done), 32'd0);
        check("arst_res",   32'(get_res(8)), 32'd0);
        check("arst_state", 32'(bus8.state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (bus8.done || bus8.busy) bad++;
        end
        check("arst_no_done", 32'(bad), 32'd0);
        run_op(8, 8'h80, 8'h80, 1'b0, 9'h000, res, lat, busy_n, done_n, hold_bad);
        check("arst_fresh_res", 32'(res), 32'h100);
        check("arst_fresh_lat", 32'(lat), 32'd8);
        prev8 = res;

        // Random sweep at both widths against the arithmetic model
        for (int w = 3; w <= 8; w += 5) begin
            done_total = 0;
            hold_total = 0;
            lat_bad = 0;
            for (int n = 0; n < 1000; n++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                exp_q.push_back(model(w, ra, rb, rc));
                run_op(w, ra, rb, rc, (w == 8) ? prev8 : prev3, res, lat, busy_n, done_n, hold_bad);
                exp = exp_q.pop_front();
                check($sformatf("rnd_w%0d_n%0d", w, n), 32'(res), 32'(exp));
                if (lat != w || busy_n != w + 1) lat_bad++;
                done_total += done_n;
                hold_total += hold_bad;
                if (w == 8) prev8 = exp; else prev3 = exp;
                repeat ($urandom_range(0, 2)) tick();
            end
            check($sformatf("rnd_w%0d_done_count", w), 32'(done_total), 32'd1000);
            check($sformatf("rnd_w%0d_timing", w), 32'(lat_bad), 32'd0);
            check($sformatf("rnd_w%0d_hold", w), 32'(hold_total), 32'd0);
        end

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
